// File: rtl/cpu_mem_pkg.sv
// Shared types for the MEM-stage data memory: word width, FSM states and captured op kinds.
package cpu_mem_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;
    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_ERR} mem_op_t;

    // True when every address bit above the implemented word-address bits is zero.
    function automatic logic addr_in_range(input logic [WORD_W-1:0] a, input int bits);
        return (a >> bits) == '0;
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word storage: synchronous write, combinational read, no reset (contents undefined until written).
module mem_word_array
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] idx,
    input  logic [WORD_W-1:0]    wdata,
    output logic [WORD_W-1:0]    rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we)
            mem[idx] <= wdata;
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_unit.sv
// MEM-stage data memory responder: captures a load/store, waits LATENCY cycles, then acks
// with a one-cycle pulse while holding the pipeline via a combinational stall.
module data_mem_unit
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2   // 1..15, fits the 4-bit wait counter
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                read_mem,
    input  logic                write_mem,
    input  logic [WORD_W-1:0]   addr,
    input  logic [WORD_W-1:0]   write_data,
    output logic [WORD_W-1:0]   read_data,
    output logic                stall,
    output logic                ack,
    output logic                err
);

    mem_state_t           state, nxt;
    mem_op_t              cap_op;
    logic [3:0]           cnt;
    logic [ADDR_BITS-1:0] cap_addr;
    logic [WORD_W-1:0]    cap_wdata;
    logic                 cap_oor;
    logic                 req;
    logic                 finish;
    logic                 arr_we;
    logic [WORD_W-1:0]    arr_rdata;

    assign req    = read_mem | write_mem;
    assign finish = (state == BUSY) && (cnt == 4'd1);
    // Only the BUSY->DONE edge commits, so an async reset before then drops the store.
    assign arr_we = finish && (cap_op == OP_WRITE) && !cap_oor;

    mem_word_array #(.ADDR_BITS(ADDR_BITS)) u_array (
        .clk   (clk),
        .we    (arr_we),
        .idx   (cap_addr),
        .wdata (cap_wdata),
        .rdata (arr_rdata)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (req) nxt = BUSY;
            BUSY:    if (cnt == 4'd1) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Gated by reset so the held-off pipeline is released the instant reset rises.
    assign stall = !reset && (((state == IDLE) && req) || (state == BUSY));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_op    <= OP_READ;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_oor   <= 1'b0;
            read_data <= '0;
            ack       <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= nxt;
            ack   <= 1'b0;
            err   <= 1'b0;
            if (state == IDLE && req) begin
                cap_op    <= (read_mem && write_mem) ? OP_ERR :
                             write_mem               ? OP_WRITE : OP_READ;
                cap_addr  <= addr[ADDR_BITS-1:0];
                cap_wdata <= write_data;
                cap_oor   <= !addr_in_range(addr, ADDR_BITS);
                cnt       <= 4'(LATENCY);
            end else if (state == BUSY) begin
                cnt <= cnt - 4'd1;
                if (finish) begin
                    ack <= 1'b1;
                    err <= (cap_op == OP_ERR) || cap_oor;
                    if (cap_op == OP_READ)
                        read_data <= cap_oor ? '0 : arr_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: table of back-to-back accesses plus reset and LATENCY=1 sequences.
module tb_data_mem_unit;
    import cpu_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rm = 1'b0, wm = 1'b0;
    logic [15:0] addr = '0, wd = '0;
    logic [15:0] rdata;
    logic        stall, ack, err;

    logic        rm1 = 1'b0, wm1 = 1'b0;
    logic [15:0] addr1 = '0, wd1 = '0;
    logic [15:0] rdata1;
    logic        stall1, ack1, err1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_unit #(.ADDR_BITS(8), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .read_mem(rm), .write_mem(wm), .addr(addr),
        .write_data(wd), .read_data(rdata), .stall(stall), .ack(ack), .err(err)
    );

    data_mem_unit #(.ADDR_BITS(8), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .read_mem(rm1), .write_mem(wm1), .addr(addr1),
        .write_data(wd1), .read_data(rdata1), .stall(stall1), .ack(ack1), .err(err1)
    );

    typedef struct {
        logic        rm;
        logic        wm;
        logic [15:0] addr;
        logic [15:0] wd;
        logic        exp_err;
        logic [15:0] exp_rd;   // read_data expected in the ack cycle
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Presents a request at the next falling edge and holds it until ack (LATENCY=2 unit).
    task automatic access(input vec_t v, input int idx, output int ack_cyc);
        int n;
        bit seen;
        @(negedge clk);
        rm = v.rm; wm = v.wm; addr = v.addr; wd = v.wd;
        #1 chk($sformatf("v%0d stall_req", idx), stall, 1'b1);
        seen = 0;
        ack_cyc = -1;
        for (n = 1; n <= 8 && !seen; n++) begin
            @(negedge clk);
            if (ack) begin
                seen = 1;
                ack_cyc = cyc;
                chk($sformatf("v%0d latency", idx), n, 3);
                chk($sformatf("v%0d err", idx), err, v.exp_err);
                chk($sformatf("v%0d read_data", idx), rdata, v.exp_rd);
                chk($sformatf("v%0d stall_done", idx), stall, 1'b0);
            end else begin
                chk($sformatf("v%0d stall_busy", idx), stall, 1'b1);
            end
        end
        if (!seen) chk($sformatf("v%0d ack_timeout", idx), 0, 1);
        rm = 1'b0; wm = 1'b0;
    endtask

    vec_t vecs[14];
    vec_t v;
    int   ac, prev_ac;

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000};
        vecs[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF};
        vecs[2]  = '{1'b0, 1'b1, 16'h0005, 16'h1234, 1'b0, 16'hBEEF};
        vecs[3]  = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'h1234};
        vecs[4]  = '{1'b0, 1'b1, 16'h0000, 16'hCAFE, 1'b0, 16'h1234};
        vecs[5]  = '{1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1, 16'h0000};
        vecs[6]  = '{1'b0, 1'b1, 16'h0100, 16'h7777, 1'b1, 16'h0000};
        vecs[7]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hCAFE};
        vecs[8]  = '{1'b0, 1'b1, 16'h0003, 16'hAAAA, 1'b0, 16'hCAFE};
        vecs[9]  = '{1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 16'hAAAA};
        vecs[10] = '{1'b1, 1'b1, 16'h0003, 16'h5555, 1'b1, 16'hAAAA};
        vecs[11] = '{1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 16'hAAAA};
        vecs[12] = '{1'b0, 1'b1, 16'h0007, 16'h0001, 1'b0, 16'hAAAA};
        vecs[13] = '{1'b1, 1'b0, 16'h0007, 16'h0000, 1'b0, 16'h0001};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst state", 32'(dut.state), 32'(IDLE));
        chk("rst cnt", dut.cnt, 0);
        chk("rst read_data", rdata, 16'h0000);
        chk("rst ack", ack, 1'b0);
        chk("rst err", err, 1'b0);
        chk("rst stall", stall, 1'b0);
        reset = 1'b0;

        // Back-to-back table: every access starts the cycle after the previous DONE
        prev_ac = -1;
        for (int i = 0; i < 14; i++) begin
            access(vecs[i], i, ac);
            if (prev_ac >= 0) chk($sformatf("v%0d ack_spacing", i), ac - prev_ac, 4);
            prev_ac = ac;
        end

        // Reset during BUSY of a store: nothing commits, outputs drop without an edge
        @(negedge clk);
        wm = 1'b1; addr = 16'h0007; wd = 16'hFFFF;
        @(negedge clk);
        chk("mid stall_busy", stall, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("mid stall", stall, 1'b0);
        chk("mid ack", ack, 1'b0);
        chk("mid err", err, 1'b0);
        chk("mid state", 32'(dut.state), 32'(IDLE));
        chk("mid read_data", rdata, 16'h0000);
        repeat (2) @(negedge clk);
        wm = 1'b0;
        reset = 1'b0;
        v = '{1'b1, 1'b0, 16'h0007, 16'h0000, 1'b0, 16'h0001};
        access(v, 100, ac);

        // LATENCY=1 unit: idle stays unstalled, then a store and a load
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("l1 idle_stall%0d", i), stall1, 1'b0);
        end
        wm1 = 1'b1; addr1 = 16'h0002; wd1 = 16'h0042;
        #1 chk("l1 stall c0", stall1, 1'b1);
        @(negedge clk);
        chk("l1 stall c1", stall1, 1'b1);
        chk("l1 ack c1", ack1, 1'b0);
        @(negedge clk);
        chk("l1 ack c2", ack1, 1'b1);
        chk("l1 stall c2", stall1, 1'b0);
        chk("l1 err c2", err1, 1'b0);
        wm1 = 1'b0;
        @(negedge clk);
        rm1 = 1'b1; addr1 = 16'h0002;
        repeat (2) @(negedge clk);
        chk("l1 load ack", ack1, 1'b1);
        chk("l1 load data", rdata1, 16'h0042);
        rm1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("l1 idle after", stall1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
